// File: rtl/rpn_pkg.sv
// rpn_pkg: opcodes, error codes and FSM state encoding shared by the RPN engine.
package rpn_pkg;
    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_OVER    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
endpackage

// File: rtl/rpn_mul_seq.sv
// rpn_mul_seq: shift-add multiplier; the start edge performs the first step, so the
// product is ready and done pulses W cycles after start.
module rpn_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);
    localparam int CW = $clog2(W);
    logic [W-1:0]  a_r;
    logic [CW-1:0] cnt;
    function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p, input logic [W-1:0] m);
        logic [W:0] hi;
        hi = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
        return {hi, p[W-1:1]};
    endfunction
    assign busy = cnt != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                prod <= step({{W{1'b0}}, b}, a);
                cnt  <= CW'(W - 1);
            end else if (busy) begin
                prod <= step(prod, a_r);
                cnt  <= cnt - 1'b1;
                done <= cnt == CW'(1);
            end
        end
    end
endmodule

// File: rtl/rpn_stack_core.sv
// rpn_stack_core: RPN operand stack and ALU behind a valid/ready op port.
// The EXEC state is the retire cycle: done pulses and a new op may be accepted.
module rpn_stack_core
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] next,
    output logic [CNT_W-1:0]  depth,
    output logic              done,
    output logic              carry,
    output logic [1:0]        err
);
    logic [1:0]          state;
    logic [DATA_W-1:0]   stk [DEPTH];
    logic [DATA_W:0]     sum, diff;
    logic [2*DATA_W-1:0] prod;
    logic [1:0]          fault;
    logic                accept, mul_start, mul_busy, mul_done;
    assign top       = stk[0];
    assign next      = stk[1];
    assign op_ready  = state != ST_MUL && !mul_busy;
    assign done      = state == ST_EXEC;
    assign accept    = op_valid && op_ready;
    assign sum       = {1'b0, stk[1]} + {1'b0, stk[0]};
    assign diff      = {1'b0, stk[1]} - {1'b0, stk[0]};
    // Popped slots are zero-filled, so top/next read 0 past the valid depth.
    assign fault = ((op_code == OP_POP || op_code == OP_DUP) && depth == '0) ? ERR_UNDER :
                   ((op_code inside {OP_ADD, OP_SUB, OP_MUL, OP_SWAP}) && depth < CNT_W'(2)) ? ERR_UNDER :
                   ((op_code == OP_PUSH || op_code == OP_DUP) && depth == CNT_W'(DEPTH)) ? ERR_OVER :
                   ERR_OK;
    assign mul_start = accept && op_code == OP_MUL && fault == ERR_OK;
    rpn_mul_seq #(.W(DATA_W)) u_mul (
        .clk  (CLOCK_50),
        .rst  (reset),
        .start(mul_start),
        .a    (stk[1]),
        .b    (stk[0]),
        .busy (mul_busy),
        .done (mul_done),
        .prod (prod)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            depth <= '0;
            carry <= 1'b0;
            err   <= ERR_OK;
            state <= ST_IDLE;
        end else if (state == ST_MUL) begin
            if (mul_done) begin
                stk[0] <= prod[DATA_W-1:0];
                for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= '0;
                depth <= depth - 1'b1;
                carry <= |prod[2*DATA_W-1:DATA_W];
                err   <= ERR_OK;
                state <= ST_EXEC;
            end
        end else if (accept) begin
            state <= mul_start ? ST_MUL : ST_EXEC;
            if (fault != ERR_OK) begin
                err   <= fault;
                carry <= 1'b0;
            end else if (op_code != OP_MUL) begin
                err   <= ERR_OK;
                carry <= op_code == OP_ADD ? sum[DATA_W] : op_code == OP_SUB ? diff[DATA_W] : 1'b0;
                case (op_code)
                    OP_PUSH, OP_DUP: begin
                        stk[0] <= op_code == OP_PUSH ? op_data : stk[0];
                        for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                        depth <= depth + 1'b1;
                    end
                    OP_POP, OP_ADD, OP_SUB: begin
                        stk[0] <= op_code == OP_ADD ? sum[DATA_W-1:0] :
                                  op_code == OP_SUB ? diff[DATA_W-1:0] : stk[1];
                        for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                        stk[DEPTH-1] <= '0;
                        depth <= depth - 1'b1;
                    end
                    OP_SWAP: begin
                        stk[0] <= stk[1];
                        stk[1] <= stk[0];
                    end
                    OP_CLR: begin
                        for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
                        depth <= '0;
                    end
                    default: ;
                endcase
            end
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_rpn_stack_core.sv
// tb_rpn_stack_core: directed table-driven checks of the RPN engine at 8x4 and 16x16.
module tb_rpn_stack_core;
    import rpn_pkg::*;
    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    int checks = 0;
    int failures = 0;
    logic        rst_a   [2];
    logic        valid_a [2];
    logic [2:0]  code_a  [2];
    logic [15:0] data_a  [2];
    logic        ready_a [2];
    logic        done_a  [2];
    logic        carry_a [2];
    logic [1:0]  err_a   [2];
    logic [15:0] top_a   [2];
    logic [15:0] next_a  [2];
    logic [4:0]  depth_a [2];
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DW = g ? 16 : 8;
        localparam int DP = g ? 16 : 4;
        localparam int CW = $clog2(DP + 1);
        logic [DW-1:0] tp, nx;
        logic [CW-1:0] dep;
        rpn_stack_core #(.DATA_W(DW), .DEPTH(DP)) dut (
            .CLOCK_50(CLOCK_50),
            .reset   (rst_a[g]),
            .op_valid(valid_a[g]),
            .op_ready(ready_a[g]),
            .op_code (code_a[g]),
            .op_data (data_a[g][DW-1:0]),
            .top     (tp),
            .next    (nx),
            .depth   (dep),
            .done    (done_a[g]),
            .carry   (carry_a[g]),
            .err     (err_a[g])
        );
        assign top_a[g]   = 16'(tp);
        assign next_a[g]  = 16'(nx);
        assign depth_a[g] = 5'(dep);
    end
    typedef struct {
        int code; int data; int top; int nxt; int dep; int cy; int er; int lat;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(int c, int d, int t, int n, int dp, int cy, int er, int lt);
        vec_t v;
        v.code = c; v.data = d; v.top = t; v.nxt = n; v.dep = dp; v.cy = cy; v.er = er; v.lat = lt;
        return v;
    endfunction
    task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (w=%0d) got=%0h want=%0h", n, k ? 16 : 8, act, exp);
        end
    endtask
    task automatic rst_seq(input int k);
        @(negedge CLOCK_50);
        rst_a[k] = 1'b1;
        valid_a[k] = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 rst_a[k] = 1'b0;
        chk("rst_depth", k, 32'(depth_a[k]), 0);
        chk("rst_top", k, 32'(top_a[k]), 0);
        chk("rst_next", k, 32'(next_a[k]), 0);
        chk("rst_ready", k, 32'(ready_a[k]), 1);
        chk("rst_done", k, 32'(done_a[k]), 0);
        chk("rst_carry", k, 32'(carry_a[k]), 0);
        chk("rst_err", k, 32'(err_a[k]), 0);
    endtask
    // Issue one op, then count cycles (and op_ready-low cycles) until done.
    task automatic op(input int k, input int c, input int d, output int lat, output int low);
        @(negedge CLOCK_50);
        chk("ready_before_op", k, 32'(ready_a[k]), 1);
        valid_a[k] = 1'b1;
        code_a[k] = 3'(c);
        data_a[k] = 16'(d);
        @(posedge CLOCK_50);
        #1 valid_a[k] = 1'b0;
        lat = 1;
        low = ready_a[k] ? 0 : 1;
        while (!done_a[k] && lat < 60) begin
            @(posedge CLOCK_50);
            #1 lat++;
            low += ready_a[k] ? 0 : 1;
        end
    endtask
    initial begin
        int lat, low, dw, dp, m, seen;
        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b1; valid_a[k] = 1'b0; code_a[k] = '0; data_a[k] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            dw = k ? 16 : 8;
            dp = k ? 16 : 4;
            m = (1 << dw) - 1;
            rst_seq(k);
            tbl.delete();
            tbl.push_back(mk(OP_PUSH, 'h29, 'h29, 0, 1, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 'hFF, 'hFF, 'h29, 2, 0, 0, 1));
            tbl.push_back(mk(OP_ADD, 0, 'h128 & m, 0, 1, ('h128 >> dw) & 1, 0, 1));
            tbl.push_back(mk(OP_CLR, 0, 0, 0, 0, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 'h0C, 'h0C, 0, 1, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 'h0B, 'h0B, 'h0C, 2, 0, 0, 1));
            tbl.push_back(mk(OP_MUL, 0, 'h84, 0, 1, 0, 0, dw + 1));
            tbl.push_back(mk(OP_PUSH, 'h20, 'h20, 'h84, 2, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 'h10, 'h10, 'h20, 3, 0, 0, 1));
            tbl.push_back(mk(OP_MUL, 0, 'h200 & m, 'h84, 2, ('h200 >> dw) != 0, 0, dw + 1));
            tbl.push_back(mk(OP_CLR, 0, 0, 0, 0, 0, 0, 1));
            tbl.push_back(mk(OP_POP, 0, 0, 0, 0, 0, 1, 1));
            tbl.push_back(mk(OP_SUB, 0, 0, 0, 0, 0, 1, 1));
            tbl.push_back(mk(OP_PUSH, 3, 3, 0, 1, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 5, 5, 3, 2, 0, 0, 1));
            tbl.push_back(mk(OP_SUB, 0, m - 1, 0, 1, 1, 0, 1));
            tbl.push_back(mk(OP_ADD, 0, m - 1, 0, 1, 0, 1, 1));
            tbl.push_back(mk(OP_MUL, 0, m - 1, 0, 1, 0, 1, 1));
            tbl.push_back(mk(OP_CLR, 0, 0, 0, 0, 0, 0, 1));
            tbl.push_back(mk(OP_PUSH, 5, 5, 0, 1, 0, 0, 1));
            tbl.push_back(mk(OP_SWAP, 0, 5, 0, 1, 0, 1, 1));
            tbl.push_back(mk(OP_PUSH, 3, 3, 5, 2, 0, 0, 1));
            tbl.push_back(mk(OP_SWAP, 0, 5, 3, 2, 0, 0, 1));
            tbl.push_back(mk(OP_DUP, 0, 5, 5, 3, 0, 0, 1));
            tbl.push_back(mk(OP_POP, 0, 5, 3, 2, 0, 0, 1));
            tbl.push_back(mk(OP_SUB, 0, m - 1, 0, 1, 1, 0, 1));
            for (int r = 0; r < tbl.size(); r++) begin
                op(k, tbl[r].code, tbl[r].data, lat, low);
                chk($sformatf("v%0d_top", r), k, 32'(top_a[k]), tbl[r].top);
                chk($sformatf("v%0d_next", r), k, 32'(next_a[k]), tbl[r].nxt);
                chk($sformatf("v%0d_depth", r), k, 32'(depth_a[k]), tbl[r].dep);
                chk($sformatf("v%0d_carry", r), k, 32'(carry_a[k]), tbl[r].cy);
                chk($sformatf("v%0d_err", r), k, 32'(err_a[k]), tbl[r].er);
                chk($sformatf("v%0d_latency", r), k, lat, tbl[r].lat);
                chk($sformatf("v%0d_ready_low", r), k, low, tbl[r].lat - 1);
            end
            // Fill to capacity, then overflow on PUSH and DUP.
            rst_seq(k);
            for (int i = 0; i < dp; i++) op(k, OP_PUSH, i + 1, lat, low);
            chk("full_depth", k, 32'(depth_a[k]), dp);
            chk("full_err", k, 32'(err_a[k]), 0);
            op(k, OP_PUSH, 'hAA, lat, low);
            chk("ovf_push_err", k, 32'(err_a[k]), 2);
            chk("ovf_push_depth", k, 32'(depth_a[k]), dp);
            chk("ovf_push_top", k, 32'(top_a[k]), dp);
            op(k, OP_DUP, 0, lat, low);
            chk("ovf_dup_err", k, 32'(err_a[k]), 2);
            chk("ovf_dup_depth", k, 32'(depth_a[k]), dp);
            op(k, OP_POP, 0, lat, low);
            chk("pop_full_err", k, 32'(err_a[k]), 0);
            chk("pop_full_top", k, 32'(top_a[k]), dp - 1);
            @(posedge CLOCK_50);
            #1 chk("done_one_pulse", k, 32'(done_a[k]), 0);
            // op_valid held through a multiply must not queue the PUSH.
            rst_seq(k);
            op(k, OP_PUSH, 6, lat, low);
            op(k, OP_PUSH, 7, lat, low);
            @(negedge CLOCK_50);
            valid_a[k] = 1'b1;
            code_a[k] = OP_MUL;
            @(posedge CLOCK_50);
            #1 code_a[k] = OP_PUSH;
            data_a[k] = 16'h55;
            lat = 1;
            while (!done_a[k] && lat < 60) begin
                @(posedge CLOCK_50);
                #1 lat++;
            end
            valid_a[k] = 1'b0;
            chk("hold_latency", k, lat, dw + 1);
            repeat (2) @(posedge CLOCK_50);
            #1 chk("hold_depth", k, 32'(depth_a[k]), 1);
            chk("hold_top", k, 32'(top_a[k]), 42);
            // Reset in the middle of a multiply aborts it without a done pulse.
            rst_seq(k);
            op(k, OP_PUSH, 9, lat, low);
            op(k, OP_PUSH, 9, lat, low);
            @(negedge CLOCK_50);
            valid_a[k] = 1'b1;
            code_a[k] = OP_MUL;
            @(posedge CLOCK_50);
            #1 valid_a[k] = 1'b0;
            seen = done_a[k];
            repeat (3) begin
                @(posedge CLOCK_50);
                #1 seen |= done_a[k];
            end
            chk("mul_busy_ready", k, 32'(ready_a[k]), 0);
            @(negedge CLOCK_50);
            rst_a[k] = 1'b1;
            @(posedge CLOCK_50);
            #1 rst_a[k] = 1'b0;
            seen |= done_a[k];
            chk("abort_depth", k, 32'(depth_a[k]), 0);
            chk("abort_top", k, 32'(top_a[k]), 0);
            chk("abort_ready", k, 32'(ready_a[k]), 1);
            chk("abort_err", k, 32'(err_a[k]), 0);
            repeat (dw + 4) begin
                @(posedge CLOCK_50);
                #1 seen |= done_a[k];
            end
            chk("abort_no_done", k, seen, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
